// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC,
// drives the instruction-memory address combinationally from it, and hands
// {instruction, pc+4} downstream through a valid/ready handshake.
//
// Control:
//   - redirect (branch/jump from a later stage) reloads the PC and flushes
//     the word currently held on the output.
//   - halt_req parks the unit in HALT: no new words are fetched, a pending
//     output word is still allowed to drain. resume returns to RUN.
//   - en=0 freezes every register, including the handshake counter.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_en                  global enable (0 = all state holds)
//   i_redirect_valid/pc   PC reload request and target (low 2 bits ignored)
//   i_halt_req, i_resume  halt / leave-halt requests
//   o_im_addr, i_im_data  instruction memory address (= PC) and read data
//   o_out_valid/ready     handshake toward IF/ID
//   o_out_inst, o_out_pc_4  fetched word and its address + 4
//   o_pc                  current PC register
//   o_halted              1 while in HALT
//   o_fetch_count         completed handshakes, wraps mod 2^CNT_W
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int                     IM_ADDR_BIT = 10,
    parameter logic [IM_ADDR_BIT-1:0] RESET_PC    = '0,
    parameter int                     CNT_W       = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic                   i_redirect_valid,
    input  logic [IM_ADDR_BIT-1:0] i_redirect_pc,
    input  logic                   i_halt_req,
    input  logic                   i_resume,
    output logic [IM_ADDR_BIT-1:0] o_im_addr,
    input  logic [31:0]            i_im_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [31:0]            o_out_inst,
    output logic [IM_ADDR_BIT-1:0] o_out_pc_4,
    output logic [IM_ADDR_BIT-1:0] o_pc,
    output logic                   o_halted,
    output logic [CNT_W-1:0]       o_fetch_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [IM_ADDR_BIT-1:0] PC_STEP   = IM_ADDR_BIT'(4);
    localparam logic [IM_ADDR_BIT-1:0] WORD_MASK = ~IM_ADDR_BIT'(3);
    // Keep the reset PC word aligned even if a misaligned value is supplied.
    localparam logic [IM_ADDR_BIT-1:0] RESET_PC_AL = RESET_PC & WORD_MASK;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t                   r_state;
    logic [IM_ADDR_BIT-1:0]   r_pc;
    logic                     r_out_valid;
    logic [31:0]              r_out_inst;
    logic [IM_ADDR_BIT-1:0]   r_out_pc_4;
    logic [CNT_W-1:0]         r_fetch_count;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t                   w_state_nxt;
    logic [IM_ADDR_BIT-1:0]   w_pc_nxt;
    logic                     w_out_valid_nxt;
    logic [31:0]              w_out_inst_nxt;
    logic [IM_ADDR_BIT-1:0]   w_out_pc_4_nxt;
    logic [CNT_W-1:0]         w_fetch_count_nxt;

    logic                     w_xfer;
    logic                     w_load;
    logic                     w_drain_valid;
    logic [IM_ADDR_BIT-1:0]   w_pc_plus4;
    logic [IM_ADDR_BIT-1:0]   w_redirect_al;

    assign w_xfer        = r_out_valid & i_out_ready;
    // Output slot is free when it is empty or being consumed this cycle.
    assign w_load        = ~r_out_valid | i_out_ready;
    // Valid after a cycle in which nothing new is loaded: only a word that
    // was not taken survives.
    assign w_drain_valid = r_out_valid & ~i_out_ready;
    // Natural wrap at the top of the address space (last word -> 0).
    assign w_pc_plus4    = r_pc + PC_STEP;
    assign w_redirect_al = i_redirect_pc & WORD_MASK;

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_out_valid_nxt   = r_out_valid;
        w_out_inst_nxt    = r_out_inst;
        w_out_pc_4_nxt    = r_out_pc_4;
        w_fetch_count_nxt = r_fetch_count;

        // A handshake always completes and is counted, even when the same
        // edge also flushes or halts.
        if (w_xfer) begin
            w_fetch_count_nxt = r_fetch_count + CNT_W'(1);
        end

        case (r_state)
            ST_RUN: begin
                if (i_redirect_valid) begin
                    // Flush: the word on the output belongs to the wrong path.
                    w_pc_nxt        = w_redirect_al;
                    w_out_valid_nxt = 1'b0;
                    if (i_halt_req) begin
                        w_state_nxt = ST_HALT;
                    end
                end else if (i_halt_req) begin
                    w_state_nxt     = ST_HALT;
                    w_out_valid_nxt = w_drain_valid;
                end else if (w_load) begin
                    w_out_inst_nxt  = i_im_data;
                    w_out_pc_4_nxt  = w_pc_plus4;
                    w_pc_nxt        = w_pc_plus4;
                    w_out_valid_nxt = 1'b1;
                end
                // else: stalled, everything holds
            end

            ST_HALT: begin
                // No fetches; a pending word can still be taken downstream.
                w_out_valid_nxt = w_drain_valid;
                if (i_redirect_valid) begin
                    w_pc_nxt = w_redirect_al;
                end
                // A simultaneous halt request keeps the unit parked.
                if (i_resume && !i_halt_req) begin
                    w_state_nxt = ST_RUN;
                end
            end

            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC_AL;
            r_out_valid   <= 1'b0;
            r_out_inst    <= '0;
            r_out_pc_4    <= '0;
            r_fetch_count <= '0;
        end else if (i_en) begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_out_inst    <= w_out_inst_nxt;
            r_out_pc_4    <= w_out_pc_4_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_im_addr     = r_pc;
    assign o_pc          = r_pc;
    assign o_out_valid   = r_out_valid;
    assign o_out_inst    = r_out_inst;
    assign o_out_pc_4    = r_out_pc_4;
    assign o_halted      = (r_state == ST_HALT);
    assign o_fetch_count = r_fetch_count;

endmodule
